// File: rtl/maze_display_scan.sv
// Maze game LED renderer: scans a 5x5 matrix one row at a time, overlays the
// blinking cursor and goal on the fixed wall map, and plays a full-matrix
// flash on reaching the goal and a cursor crosshair on hitting a wall.
// All outputs are registered; row_sel and col_drv always change together.
module maze_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_DIV    = 8,
  parameter int WIN_FLASHES  = 4,
  parameter int CRASH_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] col_pos,
  input  logic [2:0] row_pos,
  input  logic       wall_hit,
  input  logic       goal_hit,
  output logic [4:0] row_sel,
  output logic [4:0] col_drv,
  output logic       frame_tick,
  output logic       busy
);

  localparam int PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW          = $clog2(BLINK_DIV + 1);
  localparam int WIN_TOGGLES = 2 * WIN_FLASHES;
  localparam int ANIM_MAX    = (WIN_TOGGLES > CRASH_FRAMES) ? WIN_TOGGLES : CRASH_FRAMES;
  localparam int AW          = $clog2(ANIM_MAX + 1);

  // Game display mode; busy mirrors "not PLAY".
  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_WIN   = 2'd1,
    ST_CRASH = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [PW-1:0] presc;
  logic [2:0]    row_idx;
  logic [2:0]    row_next;
  logic          scan_wrap;

  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;
  logic          blink_phase;
  logic          phase_next;
  logic          blink_wrap;

  logic [AW-1:0] anim_cnt;
  logic [AW-1:0] anim_next;
  logic [AW-1:0] anim_inc;

  logic          goal_q;
  logic          wall_q;
  logic          goal_rise;
  logic          wall_rise;

  logic [4:0]    maze_mask;
  logic [4:0]    cursor_bit;
  logic [4:0]    pixels;

  assign scan_wrap  = (presc == PW'(SCAN_DIV - 1));
  assign row_next   = (row_idx == 3'd4) ? 3'd0 : row_idx + 3'd1;
  assign goal_rise  = goal_hit & ~goal_q;
  assign wall_rise  = wall_hit & ~wall_q;
  assign blink_wrap = frame_tick && (blink_cnt == BW'(BLINK_DIV - 1));
  assign anim_inc   = anim_cnt + AW'(1);

  // Fixed wall map for the row about to be selected (bit j = column j).
  always_comb begin
    case (row_next)
      3'd0:    maze_mask = 5'b01010;
      3'd1:    maze_mask = 5'b01010;
      3'd2:    maze_mask = 5'b11010;
      3'd3:    maze_mask = 5'b00010;
      3'd4:    maze_mask = 5'b10011;
      default: maze_mask = 5'b00000;
    endcase
  end

  // Cursor column as a one-hot bit; an off-board column lights nothing.
  always_comb begin
    cursor_bit = (col_pos <= 3'd4) ? (5'b00001 << col_pos) : 5'b00000;
  end

  // Column data for the next row, from the mode and blink phase in force now.
  always_comb begin
    pixels = 5'b00000;
    case (state)
      ST_PLAY: begin
        pixels = maze_mask;
        if (!blink_phase && row_next == 3'd1) pixels = pixels | 5'b00100;
        if (blink_phase && row_pos == row_next) pixels = pixels | cursor_bit;
      end
      ST_WIN:   pixels = blink_phase ? 5'b11111 : 5'b00000;
      ST_CRASH: pixels = (row_pos == row_next) ? 5'b11111 : cursor_bit;
      default:  pixels = 5'b00000;
    endcase
  end

  // Row scan: prescaler, row index, and the registered row/column outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      row_idx    <= 3'd0;
      row_sel    <= 5'b00001;
      col_drv    <= 5'b00000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= scan_wrap && (row_idx == 3'd4);
      if (scan_wrap) begin
        presc   <= '0;
        row_idx <= row_next;
        row_sel <= 5'b00001 << row_next;
        col_drv <= pixels;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // One-cycle-delayed copies of the event levels for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      goal_q <= 1'b0;
      wall_q <= 1'b0;
    end else begin
      goal_q <= goal_hit;
      wall_q <= wall_hit;
    end
  end

  // Mode register plus the blink and animation counters it owns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_PLAY;
      busy        <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      anim_cnt    <= '0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != ST_PLAY);
      blink_cnt   <= blink_cnt_next;
      blink_phase <= phase_next;
      anim_cnt    <= anim_next;
    end
  end

  // Next mode, blink and animation counts; events only act from PLAY.
  always_comb begin
    state_next     = state;
    blink_cnt_next = blink_cnt;
    phase_next     = blink_phase;
    anim_next      = anim_cnt;
    if (frame_tick) begin
      blink_cnt_next = blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) phase_next = ~blink_phase;
    end
    case (state)
      ST_PLAY: begin
        if (goal_rise) begin
          state_next     = ST_WIN;
          blink_cnt_next = '0;
          phase_next     = 1'b1;
          anim_next      = '0;
        end else if (wall_rise) begin
          state_next = ST_CRASH;
          anim_next  = '0;
        end
      end
      ST_WIN: begin
        if (blink_wrap) begin
          anim_next = anim_inc;
          if (anim_inc == AW'(WIN_TOGGLES)) begin
            state_next = ST_PLAY;
            phase_next = 1'b0;
          end
        end
      end
      ST_CRASH: begin
        if (frame_tick) begin
          anim_next = anim_inc;
          if (anim_inc == AW'(CRASH_FRAMES)) state_next = ST_PLAY;
        end
      end
      default: state_next = ST_PLAY;
    endcase
  end

endmodule

// File: tb/tb_maze_display_scan.sv
// Bench for maze_display_scan: directed scenarios followed by random
// position/event traffic. A frame-level reference model predicts every
// cycle's outputs into a queue; a monitor on the falling edge compares.
module tb_maze_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_DIV    = 1;
  localparam int WIN_FLASHES  = 2;
  localparam int CRASH_FRAMES = 3;
  localparam int FRAME_LEN    = 5 * SCAN_DIV;

  localparam int M_PLAY  = 0;
  localparam int M_WIN   = 1;
  localparam int M_CRASH = 2;

  // Clock / reset / DUT
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] col_pos = 3'd0;
  logic [2:0] row_pos = 3'd0;
  logic       wall_hit = 1'b0;
  logic       goal_hit = 1'b0;
  logic [4:0] row_sel;
  logic [4:0] col_drv;
  logic       frame_tick;
  logic       busy;

  always #5 clk = ~clk;

  maze_display_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_DIV   (BLINK_DIV),
    .WIN_FLASHES (WIN_FLASHES),
    .CRASH_FRAMES(CRASH_FRAMES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col_pos   (col_pos),
    .row_pos   (row_pos),
    .wall_hit  (wall_hit),
    .goal_hit  (goal_hit),
    .row_sel   (row_sel),
    .col_drv   (col_drv),
    .frame_tick(frame_tick),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;

  // Expected {row_sel, col_drv, frame_tick, busy} per cycle
  logic [11:0] exp_q[$];

  // Reference model: wall map as rows of column bits
  logic [4:0] maze_map [5];
  initial begin
    maze_map[0] = 5'b01010;
    maze_map[1] = 5'b01010;
    maze_map[2] = 5'b11010;
    maze_map[3] = 5'b00010;
    maze_map[4] = 5'b10011;
  end

  // Picture of one row, built column by column from the display rules.
  function automatic logic [4:0] picture(input int mode, input int phase, input int row,
                                         input int c, input int r);
    logic [4:0] p;
    p = 5'b00000;
    for (int j = 0; j < 5; j++) begin
      case (mode)
        M_PLAY:  p[j] = maze_map[row][j] || (phase == 0 && row == 1 && j == 2) ||
                        (phase == 1 && r == row && c == j);
        M_WIN:   p[j] = (phase == 1);
        default: p[j] = (r == row) || (c == j);
      endcase
    end
    return p;
  endfunction

  // Model state: cycles since release, frames consumed, epochs of the
  // current blink run and crash run.
  int         m_n, m_ticks, m_blink_epoch, m_blink_base, m_crash_epoch, m_mode, m_phase, m_row;
  bit         m_ft, m_prev_goal, m_prev_wall, m_fired, m_grise, m_wrise;
  logic [4:0] m_col;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_n = 0; m_ticks = 0; m_blink_epoch = 0; m_blink_base = 0; m_crash_epoch = 0;
      m_mode = M_PLAY; m_phase = 0; m_row = 0; m_ft = 0;
      m_prev_goal = 0; m_prev_wall = 0; m_col = 5'b00000;
    end else begin
      m_fired = m_ft;
      m_grise = goal_hit && !m_prev_goal;
      m_wrise = wall_hit && !m_prev_wall;
      m_prev_goal = goal_hit;
      m_prev_wall = wall_hit;
      m_n++;
      m_row = (m_n / SCAN_DIV) % 5;
      if (m_n % SCAN_DIV == 0) m_col = picture(m_mode, m_phase, m_row, int'(col_pos), int'(row_pos));
      if (m_fired) m_ticks++;
      case (m_mode)
        M_PLAY: begin
          if (m_grise) begin
            m_mode = M_WIN; m_blink_base = 1; m_blink_epoch = m_ticks;
          end else if (m_wrise) begin
            m_mode = M_CRASH; m_crash_epoch = m_ticks;
          end
        end
        M_WIN: begin
          if (m_ticks - m_blink_epoch == 2 * WIN_FLASHES * BLINK_DIV) begin
            m_mode = M_PLAY; m_blink_base = 0; m_blink_epoch = m_ticks;
          end
        end
        default: begin
          if (m_ticks - m_crash_epoch == CRASH_FRAMES) m_mode = M_PLAY;
        end
      endcase
      m_phase = m_blink_base ^ (((m_ticks - m_blink_epoch) / BLINK_DIV) % 2);
      m_ft = (m_n % FRAME_LEN == 0);
    end
    exp_q.push_back({5'b00001 << m_row, m_col, m_ft, (m_mode != M_PLAY)});
  end

  // Scoreboard monitor: one expected entry per cycle, compared mid-cycle.
  logic [11:0] got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {row_sel, col_drv, frame_tick, busy};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL scan t=%0t row_sel=%b col_drv=%b frame_tick=%b busy=%b, expected row_sel=%b col_drv=%b frame_tick=%b busy=%b",
                 $time, got[11:7], got[6:2], got[1], got[0], want[11:7], want[6:2], want[1], want[0]);
      end
    end
  end

  // Driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pos(input int c, input int r);
    col_pos = 3'(c);
    row_pos = 3'(r);
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (row_sel !== 5'b00001 || col_drv !== 5'b00000 || busy !== 1'b0 || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL %s row_sel=%b col_drv=%b busy=%b frame_tick=%b, expected 00001 00000 0 0",
               name, row_sel, col_drv, busy, frame_tick);
    end
  endtask

  // Stimulus
  initial begin
    // Reset held with clock running
    reset_n = 1'b0;
    run(4);
    check_reset_outputs("reset_hold");
    reset_n = 1'b1;

    // Static PLAY: cursor at the top-left corner
    set_pos(0, 0);
    run(3 * FRAME_LEN);

    // Off-board cursor column on row 2
    set_pos(5, 2);
    run(3 * FRAME_LEN);

    // Win with goal held high throughout and after
    set_pos(2, 1);
    goal_hit = 1'b1;
    run(7 * FRAME_LEN);
    goal_hit = 1'b0;
    run(FRAME_LEN);

    // Goal and wall rise together: win takes priority
    set_pos(1, 4);
    goal_hit = 1'b1;
    wall_hit = 1'b1;
    run(6 * FRAME_LEN);
    goal_hit = 1'b0;
    wall_hit = 1'b0;
    run(2);

    // Crash crosshair at row 3, column 2
    set_pos(2, 3);
    wall_hit = 1'b1;
    run(5 * FRAME_LEN);
    wall_hit = 1'b0;
    run(FRAME_LEN);

    // Random traffic, including off-board positions
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) set_pos($urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) goal_hit = ~goal_hit;
      if ($urandom_range(0, 29) == 0) wall_hit = ~wall_hit;
      run(1);
    end
    goal_hit = 1'b0;
    wall_hit = 1'b0;
    run(8 * FRAME_LEN);

    // Reset in the middle of a win animation, between clock edges
    set_pos(0, 0);
    goal_hit = 1'b1;
    run(2 * FRAME_LEN + 10);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset_mid_win");
    goal_hit = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(3 * FRAME_LEN);

    run(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
